led_matrix_scanner: RTL

Serial scan-out driver for the 16x16 red/green LED matrix. It consumes the `RedPixels`/`GrnPixels` frame produced by the display composer and drives the physical panel one row at a time. For each row it shifts 16 column bits per colour into external shift registers, latches them, selects the row, and lights it for a programmable dwell time. It snapshots a whole frame at frame start, so the panel never shows a torn image.

---
 rtl/led_matrix_scanner.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: serial scan-out driver for a 16x16 red/green LED panel.
// Snapshots a whole frame at the start of row 0, then for each row shifts 16
// column bits per colour (column 15 first), latches them, selects the row and
// lights it for DWELL_CYCLES cycles.
//
// Ports:
//   clock       system clock, rising edge
//   RST         asynchronous active-high reset
//   enable      scanning permitted (sampled in IDLE and at end of DWELL)
//   RedPixels   red frame, [row][col], 1 = lit
//   GrnPixels   green frame, same layout
//   ser_clk     panel shift clock, panel samples on rising edge
//   ser_red     red serial column data
//   ser_grn     green serial column data
//   latch       one-cycle pulse transferring shift registers to column drivers
//   row_sel     active row index
//   oe_n        active-low panel output enable
//   frame_done  one-cycle pulse on the final lit cycle of row 15
module led_matrix_scanner #(
   parameter int unsigned CYCLES_PER_BIT = 1,
   parameter int unsigned DWELL_CYCLES   = 1000
) (
   input  logic              clock,
   input  logic              RST,
   input  logic              enable,
   input  logic [15:0][15:0] RedPixels,
   input  logic [15:0][15:0] GrnPixels,
   output logic              ser_clk,
   output logic              ser_red,
   output logic              ser_grn,
   output logic              latch,
   output logic [3:0]        row_sel,
   output logic              oe_n,
   output logic              frame_done
);

   localparam int unsigned PW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(CYCLES_PER_BIT - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      LATCH,
      DWELL
   } state_t;

   state_t            state_q, state_d;
   logic [15:0][15:0] red_buf_q, red_buf_d;
   logic [15:0][15:0] grn_buf_q, grn_buf_d;
   logic [15:0]       red_sr_q, red_sr_d;
   logic [15:0]       grn_sr_q, grn_sr_d;
   logic [3:0]        bit_q, bit_d;
   logic [PW-1:0]     phase_q, phase_d;
   logic              half_q, half_d;
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [3:0]        row_q, row_d;

   logic              ser_clk_d, ser_red_d, ser_grn_d, latch_d, oe_n_d, frame_done_d;
   logic [3:0]        row_sel_d;

   // Next-state, counter and next-output logic
   always_comb begin
      state_d   = state_q;
      red_buf_d = red_buf_q;
      grn_buf_d = grn_buf_q;
      red_sr_d  = red_sr_q;
      grn_sr_d  = grn_sr_q;
      bit_d     = bit_q;
      phase_d   = phase_q;
      half_d    = half_q;
      dwell_d   = dwell_q;
      row_d     = row_q;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = LOAD;
               row_d   = '0;
            end
         end
         LOAD: begin
            // Row 0 takes the frame snapshot and loads its shifters straight
            // from the inputs, since the buffers update only at this edge.
            if (row_q == 4'd0) begin
               red_buf_d = RedPixels;
               grn_buf_d = GrnPixels;
               red_sr_d  = RedPixels[0];
               grn_sr_d  = GrnPixels[0];
            end else begin
               red_sr_d  = red_buf_q[row_q];
               grn_sr_d  = grn_buf_q[row_q];
            end
            bit_d   = '0;
            phase_d = '0;
            half_d  = 1'b0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (phase_q == PHASE_LAST) begin
               phase_d = '0;
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  half_d = 1'b0;
                  if (bit_q == 4'd15) begin
                     state_d = LATCH;
                  end else begin
                     bit_d    = bit_q + 4'd1;
                     red_sr_d = {red_sr_q[14:0], 1'b0};
                     grn_sr_d = {grn_sr_q[14:0], 1'b0};
                  end
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         LATCH: begin
            dwell_d = '0;
            state_d = DWELL;
         end
         DWELL: begin
            if (dwell_q == DWELL_LAST) begin
               if (enable) begin
                  row_d   = row_q + 4'd1;
                  state_d = LOAD;
               end else begin
                  row_d   = '0;
                  state_d = IDLE;
               end
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are derived from the next state so they register in step with it
      ser_clk_d    = (state_d == SHIFT) && half_d;
      ser_red_d    = (state_d == SHIFT) && red_sr_d[15];
      ser_grn_d    = (state_d == SHIFT) && grn_sr_d[15];
      latch_d      = (state_d == LATCH);
      row_sel_d    = (state_d == LATCH) ? row_d : row_sel;
      oe_n_d       = (state_d != DWELL);
      frame_done_d = (state_d == DWELL) && (dwell_d == DWELL_LAST) && (row_d == 4'd15);
   end

   // State, datapath and output registers
   always_ff @(posedge clock or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         red_buf_q  <= '0;
         grn_buf_q  <= '0;
         red_sr_q   <= '0;
         grn_sr_q   <= '0;
         bit_q      <= '0;
         phase_q    <= '0;
         half_q     <= 1'b0;
         dwell_q    <= '0;
         row_q      <= '0;
         ser_clk    <= 1'b0;
         ser_red    <= 1'b0;
         ser_grn    <= 1'b0;
         latch      <= 1'b0;
         row_sel    <= '0;
         oe_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         red_buf_q  <= red_buf_d;
         grn_buf_q  <= grn_buf_d;
         red_sr_q   <= red_sr_d;
         grn_sr_q   <= grn_sr_d;
         bit_q      <= bit_d;
         phase_q    <= phase_d;
         half_q     <= half_d;
         dwell_q    <= dwell_d;
         row_q      <= row_d;
         ser_clk    <= ser_clk_d;
         ser_red    <= ser_red_d;
         ser_grn    <= ser_grn_d;
         latch      <= latch_d;
         row_sel    <= row_sel_d;
         oe_n       <= oe_n_d;
         frame_done <= frame_done_d;
      end
   end

endmodule
